loop_nest_counter: RTL and testbench

Parametrised successor to the single-level fixed-II iteration counters. It generates the iteration space of a DIMS-deep perfect loop nest, with runtime trip counts latched at start. One iteration is issued every II cycles, with a stall input that freezes issue. Output is the index vector plus valid/last/done flags; it sits between the schedule controller and the address generators / SRAM ports.

---
 rtl/loop_nest_counter.sv | 134 +++++++++++++
 tb/tb_loop_nest_counter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/loop_nest_counter.sv
// loop_nest_counter: DIMS-deep perfect loop nest iterator, one issue every II unstalled cycles.
// Define LOOP_NEST_ITER_COUNT_EN to add a saturating 32-bit issued-iteration counter.
module loop_nest_counter #(
  parameter int DIMS  = 2,
  parameter int IDX_W = 16,
  parameter int II    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stall,
  input  logic [DIMS*IDX_W-1:0] bounds,
  output logic [DIMS*IDX_W-1:0] idx,
  output logic                  valid,
  output logic                  last,
  output logic                  busy,
  output logic                  done
`ifdef LOOP_NEST_ITER_COUNT_EN
  ,
  output logic [31:0]           iter_count
`endif
);

  localparam int GW = (II > 1) ? $clog2(II) : 1;
  localparam logic [GW-1:0] GAP_RELOAD = GW'(II - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                     state_q;
  logic [DIMS-1:0][IDX_W-1:0] bnd_in;
  logic [DIMS-1:0][IDX_W-1:0] bnd_q;
  logic [DIMS-1:0][IDX_W-1:0] idx_q;
  logic [DIMS-1:0][IDX_W-1:0] idx_nxt;
  logic [GW-1:0]              gap_q;
  logic [DIMS-1:0]            at_max;
  logic                       at_end;
  logic                       any_zero;

  assign bnd_in = bounds;
  assign idx    = idx_q;

  // Per-dim wrap detection, zero-trip detection and odometer successor
  always_comb begin
    logic carry;
    carry    = 1'b1;
    any_zero = 1'b0;
    at_max   = '0;
    idx_nxt  = idx_q;
    for (int d = 0; d < DIMS; d++) begin
      at_max[d] = (idx_q[d] == bnd_q[d] - IDX_W'(1));
      any_zero  = any_zero | (bnd_in[d] == '0);
      unique case (1'b1)
        (!carry):               idx_nxt[d] = idx_q[d];
        (carry && at_max[d]):   idx_nxt[d] = '0;
        (carry && !at_max[d]):  idx_nxt[d] = idx_q[d] + IDX_W'(1);
      endcase
      carry = carry & at_max[d];
    end
  end

  assign at_end = &at_max;
  assign valid  = (state_q == S_RUN) && (gap_q == '0) && !stall;
  assign last   = valid && at_end;

  // Control FSM with registered busy/done, index and issue-gap state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      bnd_q   <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            bnd_q <= bnd_in;
            idx_q <= '0;
            gap_q <= '0;
            if (any_zero) begin
              state_q <= S_DONE;
              done    <= 1'b1;
            end else begin
              state_q <= S_RUN;
              busy    <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (valid) begin
            idx_q <= idx_nxt;
            gap_q <= GAP_RELOAD;
            if (at_end) begin
              state_q <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              idx_q   <= '0;
            end
          end else if (!stall && gap_q != '0) begin
            gap_q <= gap_q - GW'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          idx_q   <= '0;
        end
        default: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef LOOP_NEST_ITER_COUNT_EN
  // Issued-iteration count, cleared on accepted start, saturating
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iter_count <= '0;
    end else if (state_q == S_IDLE && start) begin
      iter_count <= '0;
    end else if (valid && iter_count != '1) begin
      iter_count <= iter_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_loop_nest_counter.sv
// tb_loop_nest_counter: II=1 and II=3 instances on shared stimulus,
// hand tables for the directed cases plus random stimulus against a nest model.
module tb_loop_nest_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic stall = 1'b0;
  logic [31:0] bounds = '0;

  logic [1:0][31:0] idx_o;
  logic [1:0] v_o, l_o, b_o, d_o;
`ifdef LOOP_NEST_ITER_COUNT_EN
  logic [1:0][31:0] ic_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  loop_nest_counter #(.DIMS(2), .IDX_W(16), .II(1)) u_a (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .bounds(bounds), .idx(idx_o[0]), .valid(v_o[0]),
    .last(l_o[0]), .busy(b_o[0]), .done(d_o[0])
`ifdef LOOP_NEST_ITER_COUNT_EN
    , .iter_count(ic_o[0])
`endif
  );

  loop_nest_counter #(.DIMS(2), .IDX_W(16), .II(3)) u_b (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .bounds(bounds), .idx(idx_o[1]), .valid(v_o[1]),
    .last(l_o[1]), .busy(b_o[1]), .done(d_o[1])
`ifdef LOOP_NEST_ITER_COUNT_EN
    , .iter_count(ic_o[1])
`endif
  );

  // nest model: phase 0 idle, 1 issuing, 2 done pulse
  int m_st[2];
  int m_k[2];
  int m_ns[2];
  int m_n[2];
  int m_b0[2];
  int m_b1[2];
  longint m_cnt[2];

  function automatic int ii_of(int u);
    return (u == 0) ? 1 : 3;
  endfunction

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int u = 0; u < 2; u++) begin
      m_st[u] = 0; m_k[u] = 0; m_ns[u] = 0; m_n[u] = 0;
      m_b0[u] = 0; m_b1[u] = 0; m_cnt[u] = 0;
    end
  endfunction

  // issue allowed once II-1 unstalled cycles have passed since the last issue
  function automatic bit exp_valid(int u);
    return m_st[u] == 1 && !stall &&
           (m_k[u] == 0 || m_ns[u] >= ii_of(u) - 1);
  endfunction

  function automatic void check_all();
    if (!rst) model_reset();
    for (int u = 0; u < 2; u++) begin
      bit ev;
      logic [31:0] ei;
      ev = exp_valid(u);
      ei = '0;
      if (m_st[u] == 1) begin
        ei[15:0]  = 16'(m_k[u] % m_b0[u]);
        ei[31:16] = 16'((m_k[u] / m_b0[u]) % m_b1[u]);
      end
      chk($sformatf("valid%0d", u), v_o[u], ev);
      chk($sformatf("last%0d", u), l_o[u], ev && m_k[u] == m_n[u] - 1);
      chk($sformatf("busy%0d", u), b_o[u], m_st[u] == 1);
      chk($sformatf("done%0d", u), d_o[u], m_st[u] == 2);
      chk($sformatf("idx%0d", u), idx_o[u], ei);
`ifdef LOOP_NEST_ITER_COUNT_EN
      chk($sformatf("iter_count%0d", u), ic_o[u], m_cnt[u]);
`endif
    end
  endfunction

  function automatic void model_update();
    if (!rst) begin
      model_reset();
      return;
    end
    for (int u = 0; u < 2; u++) begin
      case (m_st[u])
        0: if (start) begin
          m_b0[u] = int'(bounds[15:0]);
          m_b1[u] = int'(bounds[31:16]);
          m_n[u] = m_b0[u] * m_b1[u];
          m_cnt[u] = 0;
          m_k[u] = 0;
          m_ns[u] = 0;
          m_st[u] = (m_n[u] == 0) ? 2 : 1;
        end
        1: if (exp_valid(u)) begin
          if (m_k[u] == m_n[u] - 1) m_st[u] = 2;
          m_k[u]++;
          m_ns[u] = 0;
          if (m_cnt[u] < 64'hFFFF_FFFF) m_cnt[u]++;
        end else if (!stall) begin
          m_ns[u]++;
        end
        default: m_st[u] = 0;
      endcase
    end
  endfunction

  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  typedef struct {
    int          len;
    logic [31:0] st;
    logic [31:0] sl;
    logic [31:0] bd0;
    logic [31:0] bd1;
    logic [31:0] va;
    logic [31:0] la;
    logic [31:0] ba;
    logic [31:0] da;
    logic [31:0] vb;
    logic [31:0] lb;
    logic [31:0] db;
  } vec_t;

  vec_t tbl[4];

  function automatic logic [15:0] rb();
    return ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 4));
  endfunction

  initial begin
    // bit c of each mask is cycle c of the segment; bounds {d1,d0}
    tbl[0] = '{19, 32'h1, 32'h0, 32'h0002_0003, 32'h0002_0003,
               32'h7E, 32'h40, 32'h7E, 32'h80,
               32'h12492, 32'h10000, 32'h20000};
    tbl[1] = '{21, 32'h1, 32'h18, 32'h0002_0003, 32'h0002_0003,
               32'h1E6, 32'h100, 32'h1FE, 32'h200,
               32'h49242, 32'h40000, 32'h80000};
    tbl[2] = '{3, 32'h1, 32'h0, 32'h0002_0000, 32'h0002_0000,
               32'h0, 32'h0, 32'h0, 32'h2,
               32'h0, 32'h0, 32'h2};
    tbl[3] = '{19, 32'h9, 32'h0, 32'h0002_0003, 32'h0003_0001,
               32'h7E, 32'h40, 32'h7E, 32'h80,
               32'h12492, 32'h10000, 32'h20000};

    model_reset();
    #1 rst = 1'b0;
    #1;
    chk("rst_valid", v_o, 2'b00);
    chk("rst_busy", b_o, 2'b00);
    chk("rst_done", d_o, 2'b00);
    chk("rst_idx", idx_o, 64'h0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    for (int s = 0; s < 4; s++) begin
      int j;
      j = 0;
      for (int c = 0; c < tbl[s].len; c++) begin
        start  = tbl[s].st[c];
        stall  = tbl[s].sl[c];
        bounds = (c == 0) ? tbl[s].bd0 : tbl[s].bd1;
        @(negedge clk);
        check_all();
        chk($sformatf("tbl%0d_c%0d_valid_a", s, c), v_o[0], tbl[s].va[c]);
        chk($sformatf("tbl%0d_c%0d_last_a", s, c), l_o[0], tbl[s].la[c]);
        chk($sformatf("tbl%0d_c%0d_busy_a", s, c), b_o[0], tbl[s].ba[c]);
        chk($sformatf("tbl%0d_c%0d_done_a", s, c), d_o[0], tbl[s].da[c]);
        chk($sformatf("tbl%0d_c%0d_valid_b", s, c), v_o[1], tbl[s].vb[c]);
        chk($sformatf("tbl%0d_c%0d_last_b", s, c), l_o[1], tbl[s].lb[c]);
        chk($sformatf("tbl%0d_c%0d_done_b", s, c), d_o[1], tbl[s].db[c]);
        if (tbl[s].va[c]) begin
          chk($sformatf("tbl%0d_c%0d_idx_a", s, c), idx_o[0],
              {16'(j / 3), 16'(j % 3)});
          j++;
        end
        @(posedge clk);
        model_update();
        #1;
      end
      start = 1'b0;
`ifdef LOOP_NEST_ITER_COUNT_EN
      if (s == 0) chk("iter_count_clean", ic_o, {32'd6, 32'd6});
      if (s == 2) chk("iter_count_zero_trip", ic_o, 64'h0);
`endif
    end

    // reset in cycle 4 of a run
    bounds = 32'h0002_0003;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("mr_valid", v_o, 2'b00);
    chk("mr_busy", b_o, 2'b00);
    chk("mr_done", d_o, 2'b00);
    chk("mr_idx", idx_o, 64'h0);
`ifdef LOOP_NEST_ITER_COUNT_EN
    chk("mr_iter_count", ic_o, 64'h0);
`endif
    tick();
    tick();
    rst = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    begin
      int n;
      n = 0;
      while ((m_st[0] != 0 || m_st[1] != 0) && n < 60) begin
        tick();
        n++;
      end
      chk("mr_rerun_timeout", n >= 60, 1'b0);
    end
`ifdef LOOP_NEST_ITER_COUNT_EN
    chk("mr_rerun_iter_count", ic_o, {32'd6, 32'd6});
`endif

    for (int i = 0; i < 1500; i++) begin
      start  = ($urandom_range(0, 3) == 0);
      stall  = ($urandom_range(0, 3) == 0);
      bounds = {rb(), rb()};
      rst    = ($urandom_range(0, 199) != 0);
      tick();
    end

    rst = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    begin
      int n;
      n = 0;
      while ((m_st[0] != 0 || m_st[1] != 0) && n < 200) begin
        tick();
        n++;
      end
      chk("drain_timeout", n >= 200, 1'b0);
    end
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
